// File: rtl/adder_sweep_checker.sv
// -----------------------------------------------------------------------------
// adder_sweep_checker
//
// Self-test companion for a WIDTH-bit combinational adder. On start it walks
// every operand pair (op_a, op_b) in order (0,0),(0,1)..(all ones, all ones).
// Each pair is held for SETTLE+1 cycles, then the adder result z_in is sampled
// and compared against the zero-extended sum. The block reports whether every
// pair matched, how many did not, and the first pair that failed.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   ena        in   clock enable; when low every register holds
//   start      in   begin a sweep (sampled in IDLE or DONE with ena=1)
//   op_a       out  operand a driven to the adder (registered)
//   op_b       out  operand b driven to the adder (registered, fastest)
//   z_in       in   adder result, WIDTH+1 bits
//   busy       out  sweep in progress
//   done       out  sweep finished, held until the next start
//   pass       out  valid with done: no mismatching pair was seen
//   err_count  out  number of mismatching pairs (wide enough to never wrap)
//   fail_a     out  op_a of the first mismatch
//   fail_b     out  op_b of the first mismatch
//   fail_z     out  z_in captured at the first mismatch
//
// SETTLE must lie in 0..15 (4-bit settle counter).
// -----------------------------------------------------------------------------
module adder_sweep_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ena,
    input  logic               start,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    input  logic [WIDTH:0]     z_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic [WIDTH:0]     fail_z
);

    localparam logic [3:0]         SETTLE_LAST = 4'(SETTLE);
    localparam logic [2*WIDTH-1:0] PAIR_ONE    = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH:0]   ERR_ZERO    = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state;
    logic [3:0]         settle_cnt;

    logic [WIDTH:0]     expected;
    logic               mismatch;
    logic               last_pair;
    logic [2*WIDTH-1:0] pair_next;
    logic [2*WIDTH:0]   err_next;

    // Compare path and next-value helpers for the CHECK state.
    // NOTE: every signal written here gets a value on every pass through the
    // block; leaving one unassigned on some path would infer a latch.
    always_comb begin
        expected  = {1'b0, op_a} + {1'b0, op_b};
        mismatch  = (z_in != expected);
        last_pair = &{op_a, op_b};
        pair_next = {op_a, op_b} + PAIR_ONE;
        err_next  = err_count;
        if (mismatch) begin
            err_next = err_count + {{(2*WIDTH){1'b0}}, 1'b1};
        end
    end

    // Single-process FSM with registered outputs.
    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            op_a       <= '0;
            op_b       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_z     <= '0;
        end else if (ena) begin
            case (state)
                S_IDLE, S_DONE: begin
                    // From DONE with start low, all results simply hold.
                    if (start) begin
                        state      <= S_SETTLE;
                        settle_cnt <= '0;
                        op_a       <= '0;
                        op_b       <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        fail_z     <= '0;
                    end
                end

                S_SETTLE: begin
                    // SETTLE+1 cycles here: counter runs 0..SETTLE inclusive.
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                S_CHECK: begin
                    if (mismatch) begin
                        err_count <= err_next;
                        // Only the very first mismatch of the sweep is kept.
                        if (err_count == ERR_ZERO) begin
                            fail_a <= op_a;
                            fail_b <= op_b;
                            fail_z <= z_in;
                        end
                    end
                    if (last_pair) begin
                        // Terminate on the all-ones pair; operands never wrap.
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == ERR_ZERO);
                    end else begin
                        // op_b is the low half, so it advances fastest.
                        {op_a, op_b} <= pair_next;
                        settle_cnt   <= '0;
                        state        <= S_SETTLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_sweep_checker.sv
// -----------------------------------------------------------------------------
// tb_adder_sweep_checker
//
// Bench for adder_sweep_checker. The main instance (SETTLE=2) sees an adder
// modelled as a 256-entry lookup table indexed by {op_a, op_b}; the table holds
// the true sum except where a test plants faults. Expected results come from
// walking that table in sweep order. A second instance (SETTLE=0) with an
// always-correct adder covers the start-held-high behaviour.
// -----------------------------------------------------------------------------
module tb_adder_sweep_checker;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;

    // Main instance, SETTLE = 2
    logic             ena;
    logic             start;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH:0]   z_in;
    logic             busy, done, pass;
    logic [2*WIDTH:0] err_count;
    logic [WIDTH-1:0] fail_a, fail_b;
    logic [WIDTH:0]   fail_z;

    // Second instance, SETTLE = 0
    logic             ena1;
    logic             start1;
    logic [WIDTH-1:0] op_a1, op_b1;
    logic [WIDTH:0]   z_in1;
    logic             busy1, done1, pass1;
    logic [2*WIDTH:0] err_count1;
    logic [WIDTH-1:0] fail_a1, fail_b1;
    logic [WIDTH:0]   fail_z1;

    logic [WIDTH:0]   ztab [256];

    int vectors     = 0;
    int miscompares = 0;

    assign z_in  = ztab[{op_a, op_b}];
    assign z_in1 = {1'b0, op_a1} + {1'b0, op_b1};

    adder_sweep_checker #(.WIDTH(WIDTH), .SETTLE(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .ena       (ena),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .z_in      (z_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_a    (fail_a),
        .fail_b    (fail_b),
        .fail_z    (fail_z)
    );

    adder_sweep_checker #(.WIDTH(WIDTH), .SETTLE(0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .ena       (ena1),
        .start     (start1),
        .op_a      (op_a1),
        .op_b      (op_b1),
        .z_in      (z_in1),
        .busy      (busy1),
        .done      (done1),
        .pass      (pass1),
        .err_count (err_count1),
        .fail_a    (fail_a1),
        .fail_b    (fail_b1),
        .fail_z    (fail_z1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Table fill helpers
    task automatic fill_golden();
        for (int i = 0; i < 256; i++) ztab[i] = 5'(i / 16 + i % 16);
    endtask

    task automatic fill_zero();
        for (int i = 0; i < 256; i++) ztab[i] = '0;
    endtask

    // Run one sweep on the main instance from a start pulse until done.
    // toggle: enable only every other edge. pulse_at: cycle of an extra start
    // pulse while busy (-1 for none). Operand order is checked on every change.
    task automatic sweep(input bit toggle, input int pulse_at, output int cyc, output int changes);
        logic [7:0] last;
        ena   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        cyc     = 0;
        changes = 0;
        last    = 8'd0;
        while (!done && cyc < 6000) begin
            if (toggle) ena = cyc[0];
            start = (cyc == pulse_at);
            @(posedge clk); #1;
            cyc++;
            if ({op_a, op_b} != last) begin
                check("pair_order", {op_a, op_b}, 8'(last + 8'd1));
                last = {op_a, op_b};
                changes++;
            end
        end
        ena   = 1'b1;
        start = 1'b0;
        check("done_reached", done, 1);
    endtask

    // Reference: walk the adder table in sweep order using plain arithmetic.
    task automatic check_results(input string name, input int cyc, input int exp_cyc, input int changes);
        int          exp_err;
        logic [3:0]  fa, fb;
        logic [4:0]  fz;
        exp_err = 0;
        fa = '0; fb = '0; fz = '0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (int'(ztab[a*16+b]) != a + b) begin
                    if (exp_err == 0) begin
                        fa = 4'(a); fb = 4'(b); fz = ztab[a*16+b];
                    end
                    exp_err++;
                end
            end
        end
        check({name, "_latency"}, cyc, exp_cyc);
        check({name, "_pairs"}, changes, 255);
        check({name, "_busy"}, busy, 0);
        check({name, "_pass"}, pass, (exp_err == 0));
        check({name, "_err_count"}, err_count, exp_err);
        check({name, "_fail_a"}, fail_a, fa);
        check({name, "_fail_b"}, fail_b, fb);
        check({name, "_fail_z"}, fail_z, fz);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_op"}, {op_a, op_b}, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_pass"}, pass, 0);
        check({name, "_err_count"}, err_count, 0);
        check({name, "_fail"}, {fail_a, fail_b, fail_z}, 0);
    endtask

    initial begin
        int cyc, changes, n, idx, t, prev, seen;

        reset  = 1'b0;
        ena    = 1'b1;
        start  = 1'b0;
        ena1   = 1'b1;
        start1 = 1'b0;
        fill_golden();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        // start while ena=0 is ignored
        ena   = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("ena_low_busy", busy, 0);
        check("ena_low_op", {op_a, op_b}, 0);
        start = 1'b0;
        ena   = 1'b1;

        // Golden adder
        fill_golden();
        sweep(1'b0, -1, cyc, changes);
        check_results("golden", cyc, 1024, changes);

        // DONE holds while start stays low
        repeat (5) @(posedge clk);
        #1;
        check("done_hold", done, 1);
        check("pass_hold", pass, 1);

        // Adder output stuck at zero
        fill_zero();
        sweep(1'b0, -1, cyc, changes);
        check_results("zero", cyc, 1024, changes);

        // Only the last pair is wrong
        fill_golden();
        ztab[255] = '0;
        sweep(1'b0, -1, cyc, changes);
        check_results("last_bad", cyc, 1024, changes);

        // Random fault patterns
        for (int r = 0; r < 3; r++) begin
            fill_golden();
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                idx = $urandom_range(0, 255);
                ztab[idx] = 5'($urandom_range(0, 31));
            end
            sweep(1'b0, -1, cyc, changes);
            check_results("random", cyc, 1024, changes);
        end

        // ena toggling every other cycle doubles the wall-clock time
        fill_golden();
        sweep(1'b1, -1, cyc, changes);
        check_results("ena_toggle", cyc, 2048, changes);

        // start pulse mid-sweep has no effect
        sweep(1'b0, 100, cyc, changes);
        check_results("mid_start", cyc, 1024, changes);

        // Reset mid-sweep at pair (7,3), with a faulty adder so state is non-zero
        fill_zero();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while ({op_a, op_b} != 8'h73 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        check("reach_7_3", {op_a, op_b}, 8'h73);
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk); #1;
        check_all_zero("mid_reset_held");
        reset = 1'b1;
        @(posedge clk); #1;
        fill_golden();
        sweep(1'b0, -1, cyc, changes);
        check_results("after_reset", cyc, 1024, changes);

        // SETTLE=0 instance with start held high: done every 513 cycles
        start1 = 1'b1;
        @(posedge clk); #1;
        t    = 0;
        prev = 0;
        seen = 0;
        while (seen < 3 && t < 2000) begin
            @(posedge clk); #1;
            t++;
            if (done1) begin
                check("hold_period", t - prev, (seen == 0) ? 512 : 513);
                check("hold_pass", pass1, 1);
                prev = t;
                seen++;
            end
        end
        check("hold_dones", seen, 3);
        start1 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder_sweep_checker.md
Name: adder_sweep_checker

Overview:
- Initiator/checker for the team's 4-bit combinational adder (`tt_um_adder` style: two 4-bit operands in, 5-bit sum out).
- On `start`, sweeps every operand pair (a, b) in 0..15 × 0..15, drives each pair to the adder and waits a settle window.
- It then samples the adder's 5-bit result and compares it against a+b.
- Reports pass/fail, an error count and the first failing vector. Used on-chip as the self-test companion of the adder.

Parameters:
- WIDTH, 4, operand width; result width is WIDTH+1; sweep length 2^(2*WIDTH).
- SETTLE, 2, cycles operands are held before the result is sampled; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ena  input  1  clock enable; when low, all state holds.
- start  input  1  begin a sweep; level sampled when ena=1.
- op_a  output  WIDTH  operand a to adder (registered).
- op_b  output  WIDTH  operand b to adder (registered).
- z_in  input  WIDTH+1  adder result.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; held until next start.
- pass  output  1  valid when done=1: err_count==0.
- err_count  output  2*WIDTH+1  number of mismatching pairs; 9 bits at default, so max 256 fits with no saturation.
- fail_a  output  WIDTH  op_a of first mismatch.
- fail_b  output  WIDTH  op_b of first mismatch.
- fail_z  output  WIDTH+1  z_in captured at first mismatch.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, all outputs 0, settle counter 0.
- ena=0: FSM, counters and outputs hold. Inputs are ignored, including start.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE or DONE with start=1 (and ena=1) → SETTLE. On that edge:
  - op_a=op_b=0, err_count=0, fail_* =0, settle cnt=0.
  - busy=1, done=0, pass=0.
- IDLE with start=0: stay.
- DONE with start=0: stay; done, pass, err_count and fail_* hold.
- SETTLE:
  - If cnt==SETTLE → CHECK; else cnt++.
  - With SETTLE=0, SETTLE lasts exactly 1 cycle.
- CHECK: compare z_in against expected = zero-extended op_a + zero-extended op_b (WIDTH+1 bits, no truncation).
  - On mismatch, err_count++.
  - If err_count was 0 before this increment, capture fail_a=op_a, fail_b=op_b, fail_z=z_in.
  - If {op_a,op_b} == all ones → DONE: busy=0, done=1, pass=(final err_count==0).
  - Otherwise increment {op_a,op_b} as one 2*WIDTH counter (op_b is the low half and changes fastest), cnt=0, → SETTLE.
- Per-pair cost: SETTLE+2 cycles (SETTLE+1 in SETTLE, 1 in CHECK).
  - Operands change only on the CHECK→SETTLE edge, so they are stable ≥SETTLE+1 cycles before sampling.
- Latency: done rises 256*(SETTLE+2) enabled cycles after the start edge. At SETTLE=2 that is 1024.
- start while busy=1: ignored.
- start held high continuously: a new sweep starts the cycle after DONE is entered. done pulses for 1 cycle; this is legal.
- Reset mid-sweep: immediate return to IDLE, all outputs 0, no partial result retained.
- Counter wrap: the sweep terminates at the all-ones pair; the operand counter never wraps to 0 while busy.

Test Plan:
- Golden adder model on z_in, SETTLE=2, start pulse.
  → busy for 1024 cycles, then done=1, pass=1, err_count=0, fail_* =0; op_a/op_b visit all 256 pairs in order (0,0),(0,1)…(15,15).
- z_in tied to 0.
  → err_count=255 (only 0+0 matches), pass=0, fail_a=0, fail_b=1, fail_z=0.
- Model correct except z_in=5'd0 when op_a=15 and op_b=15.
  → err_count=1, fail_a=15, fail_b=15, fail_z=0, pass=0.
- ena toggled 1/0 every other cycle during a sweep with the golden model.
  → identical final results; done after 2048 wall-clock cycles.
- reset low for 1 cycle at op pair (7,3), then release, then start again.
  → all outputs 0 immediately on reset; second sweep completes with pass=1.
- start pulsed at cycle 100 of an active sweep; separately, start held high throughout with SETTLE=0.
  → the mid-sweep pulse has no effect. With start held high, done pulses once every 513 cycles (512 sweep cycles + 1 DONE cycle) and pass=1.
